// File: rtl/ap_pkg.sv
// Shared definitions for the AP MMIO bridge: FSM states, decode kinds,
// address-map constants, status bit positions and the clogb2 helper.
package ap_pkg;

   localparam int CELL_QUANT_DEF = 128;

   // The three CAM columns share the space below the settings block.
   localparam int CAM_A_START   = 0;
   localparam int CAM_B_START   = 2 * CELL_QUANT_DEF;
   localparam int CAM_C_START   = 4 * CELL_QUANT_DEF;
   localparam int SETTINGS_BASE = 6 * CELL_QUANT_DEF;

   // Settings-block offsets.
   localparam int CTRL_OFF = 4;
   localparam int STAT_OFF = 8;

   // Status word bit positions.
   localparam int STAT_IRQ_BIT  = 0;
   localparam int STAT_DONE_BIT = 1;
   localparam int STAT_TMO_BIT  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAM_WR,
      ST_CAM_RD,
      ST_RD_WAIT,
      ST_STAT_RD,
      ST_SET_WR,
      ST_RESP
   } state_t;

   typedef enum logic [2:0] {
      KIND_CAM_WR,
      KIND_CAM_RD,
      KIND_SET_WR,
      KIND_STAT_RD,
      KIND_ERR
   } kind_t;

   // Bits needed to hold values 0 .. value-1.
   function automatic int clogb2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if (((value - 1) >> i) != 0) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ap_addr_decode.sv
// Combinational region decode of a host request into a bridge action.
// CAM accesses are refused while the AP is locked or busy.
module ap_addr_decode
   import ap_pkg::*;
#(
   parameter int AW            = 10,
   parameter int SETTINGS_BASE = 768
) (
   input  logic [AW-1:0] addr,
   input  logic          write,
   input  logic          lock,
   input  logic          busy,
   output kind_t         kind,
   output logic          err
);

   localparam logic [AW-1:0] SET_ADDR  = AW'(SETTINGS_BASE);
   localparam logic [AW-1:0] CTRL_ADDR = AW'(SETTINGS_BASE + CTRL_OFF);
   localparam logic [AW-1:0] STAT_ADDR = AW'(SETTINGS_BASE + STAT_OFF);

   // Classify the request; anything not explicitly legal is an error.
   always_comb begin
      kind = KIND_ERR;
      err  = 1'b1;
      if (addr < SET_ADDR) begin
         if (!lock && !busy) begin
            kind = write ? KIND_CAM_WR : KIND_CAM_RD;
            err  = 1'b0;
         end
      end else if (write && (addr == SET_ADDR || addr == CTRL_ADDR)) begin
         kind = KIND_SET_WR;
         err  = 1'b0;
      end else if (!write && addr == STAT_ADDR) begin
         kind = KIND_STAT_RD;
         err  = 1'b0;
      end
   end

endmodule

// File: rtl/ap_mmio_bridge.sv
// Host MMIO front end for the AP wrapper: accepts single-beat requests,
// sequences wrapper strobes / read latency, returns one response per
// request and tracks the in-flight AP computation.
// Optional build macro AP_BRIDGE_TIMEOUT_EN adds a busy watchdog.
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_IDLE    | ready for a host request
// ST_CAM_WR  | one-cycle CAM write strobe
// ST_CAM_RD  | one-cycle CAM read strobe
// ST_RD_WAIT | waiting out the wrapper read latency
// ST_STAT_RD | sample status, clear done/timeout
// ST_SET_WR  | one-cycle settings write strobe
// ST_RESP    | response held until host consumes it
module ap_mmio_bridge
   import ap_pkg::*;
#(
   parameter int WORD_SIZE   = 8,
   parameter int CELL_QUANT  = 128,
   parameter int READ_LAT    = 2,
   parameter int TIMEOUT_CYC = 4096,
   parameter int AW          = clogb2(CELL_QUANT * 6)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          host_req_valid,
   output logic          host_req_ready,
   input  logic [AW-1:0] host_req_addr,
   input  logic          host_req_write,
   input  logic [31:0]   host_req_wdata,
   input  logic [3:0]    host_req_mask,
   output logic          host_resp_valid,
   input  logic          host_resp_ready,
   output logic [31:0]   host_resp_rdata,
   output logic          host_resp_err,
   output logic          ap_req_valid,
   output logic          ap_read_async,
   output logic          ap_settings_write_en,
   output logic [AW-1:0] ap_req_addr,
   output logic          ap_req_write,
   output logic [31:0]   ap_req_wdata,
   output logic [3:0]    ap_req_mask,
   input  logic [31:0]   ap_resp,
   output logic          busy,
   output logic          done_irq
);

   localparam int SET_BASE = CELL_QUANT * 6;
   localparam int LW       = clogb2(READ_LAT + 1);
   localparam logic [AW-1:0] CTRL_ADDR = AW'(SET_BASE + CTRL_OFF);
   localparam logic [AW-1:0] STAT_ADDR = AW'(SET_BASE + STAT_OFF);

   state_t        state_q, state_d;
   logic [AW-1:0] req_addr_q, req_addr_d;
   logic [31:0]   req_wdata_q, req_wdata_d;
   logic [3:0]    req_mask_q, req_mask_d;
   logic [LW-1:0] lat_cnt_q, lat_cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          req_ready_q, req_ready_d;
   logic          resp_valid_q, resp_valid_d;
   logic          ap_valid_q, ap_valid_d;
   logic          ap_write_q, ap_write_d;
   logic          ap_set_we_q, ap_set_we_d;
   logic [AW-1:0] ap_addr_q, ap_addr_d;
   logic [31:0]   ap_wdata_q, ap_wdata_d;
   logic [3:0]    ap_mask_q, ap_mask_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          timeout_q, timeout_d;
   logic          lock_q, lock_d;
   logic          done_irq_q, done_irq_d;
   kind_t         dec_kind;
   logic          dec_err;

   // Only the CAM word is meaningful on a data read; the rest is dropped.
   logic unused_resp_hi;
   assign unused_resp_hi = ^ap_resp[31:WORD_SIZE];

   ap_addr_decode #(.AW(AW), .SETTINGS_BASE(SET_BASE)) u_decode (
      .addr  (host_req_addr),
      .write (host_req_write),
      .lock  (lock_q),
      .busy  (busy_q),
      .kind  (dec_kind),
      .err   (dec_err)
   );

   // Request sequencing; outputs are derived from the next state so they register cleanly.
   always_comb begin
      state_d     = state_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      req_mask_d  = req_mask_q;
      lat_cnt_d   = lat_cnt_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (host_req_valid && req_ready_q) begin
               req_addr_d  = host_req_addr;
               req_wdata_d = host_req_wdata;
               req_mask_d  = host_req_mask;
               rdata_d     = '0;
               err_d       = dec_err;
               state_d     = ST_RESP;
               if (!dec_err) begin
                  case (dec_kind)
                     // A CAM write without the low byte lane is a silent no-op.
                     KIND_CAM_WR:  state_d = host_req_mask[0] ? ST_CAM_WR : ST_RESP;
                     KIND_CAM_RD:  state_d = ST_CAM_RD;
                     KIND_SET_WR:  state_d = ST_SET_WR;
                     KIND_STAT_RD: state_d = ST_STAT_RD;
                     default:      err_d   = 1'b1;
                  endcase
               end
            end
         end
         ST_CAM_WR: state_d = ST_RESP;
         ST_CAM_RD: begin
            lat_cnt_d = LW'(READ_LAT - 1);
            state_d   = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (lat_cnt_q == '0) begin
               rdata_d = {{(32 - WORD_SIZE){1'b0}}, ap_resp[WORD_SIZE-1:0]};
               state_d = ST_RESP;
            end else begin
               lat_cnt_d = lat_cnt_q - 1'b1;
            end
         end
         ST_SET_WR: state_d = ST_RESP;
         ST_STAT_RD: begin
            rdata_d                = '0;
            rdata_d[STAT_TMO_BIT]  = timeout_q;
            rdata_d[STAT_DONE_BIT] = done_q;
            rdata_d[STAT_IRQ_BIT]  = ap_resp[0];
            state_d                = ST_RESP;
         end
         ST_RESP: if (host_resp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      req_ready_d  = (state_d == ST_IDLE);
      resp_valid_d = (state_d == ST_RESP);
      ap_valid_d   = (state_d == ST_CAM_WR) || (state_d == ST_CAM_RD);
      ap_write_d   = (state_d == ST_CAM_WR);
      ap_set_we_d  = (state_d == ST_SET_WR);
      case (state_d)
         ST_CAM_WR, ST_CAM_RD, ST_SET_WR: ap_addr_d = req_addr_d;
         ST_RD_WAIT:                      ap_addr_d = req_addr_q;
         ST_STAT_RD:                      ap_addr_d = STAT_ADDR;
         default:                         ap_addr_d = '0;
      endcase
      if (state_d == ST_CAM_WR || state_d == ST_SET_WR) begin
         ap_wdata_d = req_wdata_d;
         ap_mask_d  = req_mask_d;
      end else begin
         ap_wdata_d = '0;
         ap_mask_d  = '0;
      end
   end

`ifdef AP_BRIDGE_TIMEOUT_EN
   localparam int TW = clogb2(TIMEOUT_CYC);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

   // Busy/done/timeout/lock tracking; a completion outranks a status-read clear,
   // and a fresh trigger outranks both.
   always_comb begin
      busy_d    = busy_q;
      done_d    = done_q;
      timeout_d = timeout_q;
      lock_d    = lock_q;
      if (state_q == ST_STAT_RD) begin
         done_d    = 1'b0;
         timeout_d = 1'b0;
      end
      // During RD_WAIT ap_resp carries CAM data, not the irq line.
      if (busy_q && state_q != ST_RD_WAIT && ap_resp[0]) begin
         busy_d = 1'b0;
         done_d = 1'b1;
      end
`ifdef AP_BRIDGE_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q;
      if (busy_q) begin
         if (tmo_cnt_q == TMO_LAST) begin
            busy_d    = 1'b0;
            timeout_d = 1'b1;
         end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
         end
      end
`endif
      if (state_q == ST_SET_WR && req_addr_q == CTRL_ADDR) begin
         lock_d = |req_wdata_q[23:16];
         if (|req_wdata_q[15:8]) begin
            busy_d = 1'b1;
            done_d = 1'b0;
`ifdef AP_BRIDGE_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
         end
      end
`ifdef AP_BRIDGE_TIMEOUT_EN
      if (!busy_d) tmo_cnt_d = '0;
`endif
      done_irq_d = done_d | timeout_d;
   end

   // State, request latch, flags and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         req_addr_q   <= '0;
         req_wdata_q  <= '0;
         req_mask_q   <= '0;
         lat_cnt_q    <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         ap_valid_q   <= 1'b0;
         ap_write_q   <= 1'b0;
         ap_set_we_q  <= 1'b0;
         ap_addr_q    <= '0;
         ap_wdata_q   <= '0;
         ap_mask_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         lock_q       <= 1'b0;
         done_irq_q   <= 1'b0;
`ifdef AP_BRIDGE_TIMEOUT_EN
         tmo_cnt_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         req_addr_q   <= req_addr_d;
         req_wdata_q  <= req_wdata_d;
         req_mask_q   <= req_mask_d;
         lat_cnt_q    <= lat_cnt_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         ap_valid_q   <= ap_valid_d;
         ap_write_q   <= ap_write_d;
         ap_set_we_q  <= ap_set_we_d;
         ap_addr_q    <= ap_addr_d;
         ap_wdata_q   <= ap_wdata_d;
         ap_mask_q    <= ap_mask_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
         lock_q       <= lock_d;
         done_irq_q   <= done_irq_d;
`ifdef AP_BRIDGE_TIMEOUT_EN
         tmo_cnt_q    <= tmo_cnt_d;
`endif
      end
   end

   assign host_req_ready       = req_ready_q;
   assign host_resp_valid      = resp_valid_q;
   assign host_resp_rdata      = rdata_q;
   assign host_resp_err        = err_q;
   assign ap_req_valid         = ap_valid_q;
   assign ap_read_async        = 1'b0;  // the bridge always uses the synchronous CAM strobe
   assign ap_settings_write_en = ap_set_we_q;
   assign ap_req_addr          = ap_addr_q;
   assign ap_req_write         = ap_write_q;
   assign ap_req_wdata         = ap_wdata_q;
   assign ap_req_mask          = ap_mask_q;
   assign busy                 = busy_q;
   assign done_irq             = done_irq_q;

endmodule

// File: tb/tb_ap_mmio_bridge.sv
// Directed bench for ap_mmio_bridge with a small AP wrapper model
// (byte CAM with fixed read latency, irq level on ap_resp[0]).
module tb_ap_mmio_bridge;

   localparam int AW = 10;
   localparam int SB = 768;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          host_req_valid = 1'b0;
   logic          host_req_ready;
   logic [AW-1:0] host_req_addr = '0;
   logic          host_req_write = 1'b0;
   logic [31:0]   host_req_wdata = '0;
   logic [3:0]    host_req_mask = '0;
   logic          host_resp_valid;
   logic          host_resp_ready = 1'b1;
   logic [31:0]   host_resp_rdata;
   logic          host_resp_err;
   logic          ap_req_valid;
   logic          ap_read_async;
   logic          ap_settings_write_en;
   logic [AW-1:0] ap_req_addr;
   logic          ap_req_write;
   logic [31:0]   ap_req_wdata;
   logic [3:0]    ap_req_mask;
   logic [31:0]   ap_resp;
   logic          busy;
   logic          done_irq;

   always #5 clock = ~clock;

   ap_mmio_bridge #(
      .WORD_SIZE(8), .CELL_QUANT(128), .READ_LAT(2), .TIMEOUT_CYC(16), .AW(AW)
   ) dut (
      .clock(clock), .reset(reset),
      .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
      .host_req_addr(host_req_addr), .host_req_write(host_req_write),
      .host_req_wdata(host_req_wdata), .host_req_mask(host_req_mask),
      .host_resp_valid(host_resp_valid), .host_resp_ready(host_resp_ready),
      .host_resp_rdata(host_resp_rdata), .host_resp_err(host_resp_err),
      .ap_req_valid(ap_req_valid), .ap_read_async(ap_read_async),
      .ap_settings_write_en(ap_settings_write_en), .ap_req_addr(ap_req_addr),
      .ap_req_write(ap_req_write), .ap_req_wdata(ap_req_wdata),
      .ap_req_mask(ap_req_mask), .ap_resp(ap_resp),
      .busy(busy), .done_irq(done_irq)
   );

   // ---------------- wrapper model ----------------
   logic [7:0]    cam_mem [0:1023];
   logic          p0 = 1'b0, p1 = 1'b0;
   logic [AW-1:0] rd_addr0 = '0, rd_addr1 = '0;
   logic          irq = 1'b0;
   int            n_wr = 0, n_rd = 0, n_set = 0, n_bad_set = 0;
   logic [AW-1:0] last_wr_addr = '0, last_set_addr = '0;
   logic [7:0]    last_wr_data = '0;

   initial for (int i = 0; i < 1024; i++) cam_mem[i] = 8'h00;

   always @(posedge clock) begin
      p0       <= ap_req_valid && !ap_req_write && !reset;
      rd_addr0 <= ap_req_addr;
      p1       <= p0;
      rd_addr1 <= rd_addr0;
      if (!reset) begin
         if (ap_req_valid && ap_req_write) begin
            n_wr++;
            last_wr_addr = ap_req_addr;
            last_wr_data = ap_req_wdata[7:0];
            if (ap_req_mask[0]) cam_mem[ap_req_addr] = ap_req_wdata[7:0];
         end
         if (ap_req_valid && !ap_req_write) n_rd++;
         if (ap_settings_write_en) begin
            n_set++;
            last_set_addr = ap_req_addr;
            if (ap_req_write) n_bad_set++;
         end
      end
   end

   // Upper bits of read data are junk so zero-extension is exercised.
   assign ap_resp = p1 ? {24'hA5A5A5, cam_mem[rd_addr1]} : {31'b0, irq};

   // ---------------- checking ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   logic [31:0] r_data;
   logic        r_err;
   int          r_lat;

   task automatic start_req(input logic [AW-1:0] a, input logic w,
                            input logic [31:0] d, input logic [3:0] m);
      host_req_addr  = a;
      host_req_write = w;
      host_req_wdata = d;
      host_req_mask  = m;
      host_req_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (host_req_ready) begin
            tick();
            host_req_valid = 1'b0;
            return;
         end
         tick();
      end
      host_req_valid = 1'b0;
      check("accept_timeout", {31'b0, host_req_ready}, 32'd1);
   endtask

   // r_lat counts cycles from the accept cycle to the first resp_valid cycle.
   task automatic wait_resp();
      r_lat = 1;
      while (!host_resp_valid && r_lat < 40) begin
         tick();
         r_lat++;
      end
      if (!host_resp_valid) check("resp_timeout", {31'b0, host_resp_valid}, 32'd1);
      r_data = host_resp_rdata;
      r_err  = host_resp_err;
      if (host_resp_ready) tick();
   endtask

   task automatic txn(input logic [AW-1:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] m);
      start_req(a, w, d, m);
      wait_resp();
   endtask

   function automatic logic [31:0] any_out();
      return {31'b0, |{host_req_ready, host_resp_valid, host_resp_rdata, host_resp_err,
                       ap_req_valid, ap_read_async, ap_settings_write_en, ap_req_addr,
                       ap_req_write, ap_req_wdata, ap_req_mask, busy, done_irq}};
   endfunction

   // Illegal accesses: {addr, write}
   logic [AW-1:0] err_addr [5];
   logic          err_wr   [5];

   initial begin
      int  w0, r0, s0, n;
      logic ok;

      // ---- reset ----
      reset = 1'b1;
      tick(); tick(); tick();
      check("reset_outputs", any_out(), 32'd0);
      reset = 1'b0;
      tick();
      check("ready_after_reset", {31'b0, host_req_ready}, 32'd1);

      // ---- CAM write / read ----
      w0 = n_wr;
      txn(10'h005, 1'b1, 32'h0000003C, 4'hF);
      check("wr_err", {31'b0, r_err}, 32'd0);
      check("wr_rdata", r_data, 32'd0);
      check("wr_lat", r_lat, 32'd2);
      check("wr_strobes", n_wr - w0, 32'd1);
      check("wr_addr", {22'b0, last_wr_addr}, 32'h005);
      check("wr_data", {24'b0, last_wr_data}, 32'h3C);

      r0 = n_rd;
      txn(10'h005, 1'b0, 32'h0, 4'hF);
      check("rd_data", r_data, 32'h0000003C);
      check("rd_err", {31'b0, r_err}, 32'd0);
      check("rd_lat", r_lat, 32'd4);
      check("rd_strobes", n_rd - r0, 32'd1);

      // Last CAM address below the settings block.
      txn(10'h2FF, 1'b1, 32'hFFFF00C3, 4'h1);
      check("wr_top_err", {31'b0, r_err}, 32'd0);
      txn(10'h2FF, 1'b0, 32'h0, 4'hF);
      check("rd_top_data", r_data, 32'h000000C3);

      // Write without byte lane 0 is a no-op.
      w0 = n_wr;
      txn(10'h005, 1'b1, 32'h000000FF, 4'hE);
      check("nop_err", {31'b0, r_err}, 32'd0);
      check("nop_lat", r_lat, 32'd1);
      check("nop_strobes", n_wr - w0, 32'd0);
      txn(10'h005, 1'b0, 32'h0, 4'hF);
      check("nop_readback", r_data, 32'h0000003C);

      // ---- trigger, busy, completion ----
      s0 = n_set; w0 = n_wr;
      txn(10'(SB + 4), 1'b1, 32'h00000100, 4'hF);
      check("trig_err", {31'b0, r_err}, 32'd0);
      check("trig_set_strobe", n_set - s0, 32'd1);
      check("trig_no_cam_wr", n_wr - w0 + n_bad_set, 32'd0);
      check("trig_busy", {31'b0, busy}, 32'd1);
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!busy || done_irq) ok = 1'b0;
      end
      check("busy_held", {31'b0, ok}, 32'd1);

      r0 = n_rd;
      txn(10'h010, 1'b0, 32'h0, 4'hF);
      check("busy_rd_err", {31'b0, r_err}, 32'd1);
      check("busy_rd_rdata", r_data, 32'd0);
      check("busy_rd_nostrobe", n_rd - r0, 32'd0);

      irq = 1'b1;
      tick();
      check("complete_busy", {31'b0, busy}, 32'd0);
      check("complete_irq", {31'b0, done_irq}, 32'd1);
      txn(10'(SB + 8), 1'b0, 32'h0, 4'hF);
      check("stat_rdata", r_data, 32'h00000003);
      check("stat_err", {31'b0, r_err}, 32'd0);
      check("stat_clears_irq", {31'b0, done_irq}, 32'd0);
      irq = 1'b0;

      // ---- completion in the same cycle as the status clear ----
      txn(10'(SB + 4), 1'b1, 32'h00000100, 4'hF);
      start_req(10'(SB + 8), 1'b0, 32'h0, 4'hF);
      irq = 1'b1;
      wait_resp();
      check("race_rdata", r_data, 32'h00000001);
      check("race_done_kept", {31'b0, done_irq}, 32'd1);
      check("race_busy", {31'b0, busy}, 32'd0);
      txn(10'(SB + 8), 1'b0, 32'h0, 4'hF);
      check("race_stat2", r_data, 32'h00000003);
      irq = 1'b0;

      // ---- lock ----
      txn(10'(SB + 4), 1'b1, 32'h00010000, 4'hF);
      check("lock_no_busy", {31'b0, busy}, 32'd0);
      w0 = n_wr; r0 = n_rd;
      txn(10'h020, 1'b1, 32'h00000011, 4'hF);
      check("lock_wr_err", {31'b0, r_err}, 32'd1);
      txn(10'h005, 1'b0, 32'h0, 4'hF);
      check("lock_rd_err", {31'b0, r_err}, 32'd1);
      check("lock_no_strobe", (n_wr - w0) + (n_rd - r0), 32'd0);
      s0 = n_set;
      txn(10'(SB + 0), 1'b1, 32'h00FF0000, 4'hF);
      check("set0_err", {31'b0, r_err}, 32'd0);
      check("set0_addr", {22'b0, last_set_addr}, SB);
      txn(10'h020, 1'b1, 32'h00000011, 4'hF);
      check("set0_keeps_lock", {31'b0, r_err}, 32'd1);
      txn(10'(SB + 4), 1'b1, 32'h00000000, 4'hF);
      check("unlock_strobes", n_set - s0, 32'd2);
      txn(10'h020, 1'b1, 32'h00000077, 4'hF);
      check("unlock_wr_err", {31'b0, r_err}, 32'd0);

      // ---- illegal settings accesses ----
      err_addr[0] = 10'(SB + 0);  err_wr[0] = 1'b0;
      err_addr[1] = 10'(SB + 12); err_wr[1] = 1'b1;
      err_addr[2] = 10'(SB + 8);  err_wr[2] = 1'b1;
      err_addr[3] = 10'(SB + 4);  err_wr[3] = 1'b0;
      err_addr[4] = 10'(SB + 3);  err_wr[4] = 1'b0;
      w0 = n_wr; r0 = n_rd; s0 = n_set;
      for (int i = 0; i < 5; i++) begin
         txn(err_addr[i], err_wr[i], 32'hFFFFFFFF, 4'hF);
         check($sformatf("illegal%0d_err", i), {31'b0, r_err}, 32'd1);
         check($sformatf("illegal%0d_rdata", i), r_data, 32'd0);
      end
      check("illegal_no_strobes", (n_wr - w0) + (n_rd - r0) + (n_set - s0), 32'd0);

      // ---- response backpressure ----
      host_resp_ready = 1'b0;
      txn(10'h005, 1'b0, 32'h0, 4'hF);
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (!host_resp_valid || host_resp_rdata !== 32'h3C || host_req_ready) ok = 1'b0;
      end
      check("bp_stable", {31'b0, ok}, 32'd1);
      host_resp_ready = 1'b1;
      tick();
      check("bp_released", {31'b0, host_resp_valid}, 32'd0);
      check("bp_ready_again", {31'b0, host_req_ready}, 32'd1);

      // ---- reset during RD_WAIT ----
      start_req(10'h005, 1'b0, 32'h0, 4'hF);
      tick();
      reset = 1'b1;
      tick();
      check("midreset_outputs", any_out(), 32'd0);
      reset = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (host_resp_valid) ok = 1'b1;
      end
      check("midreset_no_resp", {31'b0, ok}, 32'd0);
      check("midreset_ready", {31'b0, host_req_ready}, 32'd1);

`ifdef AP_BRIDGE_TIMEOUT_EN
      // ---- watchdog ----
      irq = 1'b0;
      start_req(10'(SB + 4), 1'b1, 32'h00000100, 4'hF);
      tick();
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
      check("tmo_busy_cycles", n, 32'd16);
      check("tmo_irq", {31'b0, done_irq}, 32'd1);
      txn(10'(SB + 8), 1'b0, 32'h0, 4'hF);
      check("tmo_stat", r_data, 32'h00000004);
      check("tmo_irq_cleared", {31'b0, done_irq}, 32'd0);
`else
      n = 0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ap_mmio_bridge.md
Name: ap_mmio_bridge

Overview:
- Host-side front end for the AP wrapper. Accepts single-beat valid/ready MMIO requests from the Rocket core's memory-mapped port.
- Decodes each request into the wrapper's CAM, settings and status regions, and sequences the wrapper's strobes and read latency.
- Returns one response per request.
- Tracks an in-flight AP computation and raises a level completion interrupt. Sits directly upstream of the AP wrapper.

Parameters:
- WORD_SIZE, 8, CAM word width; read data is zero-extended to 32 bits.
- CELL_QUANT, 128, cells per CAM column; settings base SETTINGS_BASE = CELL_QUANT*6.
- READ_LAT, 2, cycles from CAM read strobe to valid ap_resp.
- TIMEOUT_CYC, 4096, busy watchdog limit (used only with the optional feature).
- AW, clogb2(CELL_QUANT*6), local address width (derived; 10 at defaults).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- host_req_valid  in  1  request valid
- host_req_ready  out  1  request accepted when valid&ready
- host_req_addr  in  AW  local byte offset
- host_req_write  in  1  1=write
- host_req_wdata  in  32  write data
- host_req_mask  in  4  byte enables
- host_resp_valid  out  1  response valid, held until ready
- host_resp_ready  in  1  host consumes response
- host_resp_rdata  out  32  read data
- host_resp_err  out  1  decode/lock/busy error
- ap_req_valid  out  1  wrapper CAM access strobe
- ap_read_async  out  1  wrapper address-only load
- ap_settings_write_en  out  1  wrapper settings strobe
- ap_req_addr  out  AW  wrapper address
- ap_req_write  out  1  wrapper CAM write enable
- ap_req_wdata  out  32  wrapper write data
- ap_req_mask  out  4  wrapper byte mask
- ap_resp  in  32  wrapper io_resp_0
- busy  out  1  AP computation in flight
- done_irq  out  1  level interrupt, completion or timeout

Behaviour:
- Reset state:
  - FSM IDLE; all outputs 0.
  - busy, done and timeout flags cleared; lock shadow cleared.
  - Reset mid-operation abandons the request. No response is issued.
- FSM states: IDLE, CAM_WR, CAM_RD, RD_WAIT, STAT_RD, SET_WR, RESP.
- host_req_ready is 1 only in IDLE. A request is latched on the accept cycle.
- Decode of a latched request (error cases go straight to RESP with err=1, rdata=0, and no wrapper strobe):
  - addr < SETTINGS_BASE, write: CAM_WR.
    - Error if lock=1 or busy=1.
    - mask[0]=0: RESP with no strobe (no-op write, err=0).
  - addr < SETTINGS_BASE, read: CAM_RD. Error if lock=1 or busy=1.
  - addr == SETTINGS_BASE or SETTINGS_BASE+4, write: SET_WR.
  - addr == SETTINGS_BASE+8, read: STAT_RD.
  - Anything else: error. This covers settings reads of +0/+4, writes to +8, and addr > SETTINGS_BASE+8.
- CAM_WR (1 cycle): ap_req_valid=1, ap_req_write=1; addr, wdata and mask driven. Then RESP with rdata=0.
- CAM_RD (1 cycle): ap_req_valid=1, ap_req_write=0. Then RD_WAIT.
- RD_WAIT:
  - Counts READ_LAT-1 further cycles while holding ap_req_addr.
  - Captures {zero, ap_resp[WORD_SIZE-1:0]}, then RESP.
  - Total accept-to-resp_valid = READ_LAT+2 cycles.
- SET_WR (1 cycle): ap_settings_write_en=1 with ap_req_write=0, so the CAM is never written. Then RESP.
  - At +4, lock shadow <= |wdata[23:16].
  - At +4 with |wdata[15:8]: busy <= 1, done <= 0.
- STAT_RD (1 cycle):
  - Drives ap_req_addr=SETTINGS_BASE+8 with no strobes.
  - Captures rdata = {29'b0, timeout, done, ap_resp[0]}.
  - Clears done and timeout (read-to-clear), then RESP.
- Completion tracking: while busy and FSM is not in RD_WAIT, the bridge samples ap_resp[0] every cycle. The wrapper presents the irq whenever trigger=1.
  - First sample =1: busy <= 0, done <= 1.
- done_irq = done | timeout.
- Simultaneous STAT_RD clear and completion set in the same cycle: set wins. done stays 1.
- RESP: host_resp_valid=1, with rdata and err stable, until host_resp_ready. Return to IDLE on the following cycle. Back-to-back requests therefore have a 1-cycle gap.

Optional Feature:
- Macro: AP_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter runs while busy.
  - Reaching TIMEOUT_CYC-1: busy <= 0, timeout <= 1.
  - The counter clears on busy clear or reset.
- Undefined: no counter; busy clears only on completion; status bit2 reads 0.

Decomposition:
- Package ap_pkg holds:
  - state enum;
  - region constants (CAM_A/B/C starts, SETTINGS_BASE, CTRL_OFF=4, STAT_OFF=8);
  - status bit indices;
  - clogb2 function.
- One sub-module, ap_addr_decode (combinational): addr/write/lock/busy -> {kind, err}.

Test Plan:
- Write addr 0x005 data 0x3C, mask 0xF -> one-cycle ap_req_valid&ap_req_write at addr 5. Then read 0x005 with ap_resp=0x3C after READ_LAT -> rdata 0x0000003C, err=0, resp_valid 4 cycles after accept.
- Write SETTINGS_BASE+4 data 0x00000100 -> settings strobe, busy=1. Hold ap_resp[0]=0 for 20 cycles, then 1 -> busy=0, done_irq=1. STAT_RD -> rdata 0x3, done_irq drops next cycle.
- While busy, CAM read at 0x010 -> err=1, no ap_req_valid. Write +4 with 0x00010000 sets lock -> CAM write err=1.
- Read SETTINGS_BASE+0 and write SETTINGS_BASE+12 -> err=1, rdata 0, no strobes.
- Hold host_resp_ready=0 for 5 cycles -> resp_valid and rdata stable, host_req_ready=0. Assert reset during RD_WAIT -> all outputs 0 next cycle, no response.
- With AP_BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=16, trigger and never complete -> busy drops at cycle 16, status reads 0x4, done_irq=1.
